// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : decode_pkg                                                      |
// | Purpose  : Shared constants and helpers for the decode stage: datapath and |
// |            register-file defaults, instruction field positions and the     |
// |            immediate-length select encodings.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package decode_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 8;

  localparam int INSTR_W    = 16;
  localparam int REG_ADDR_W = 3;
  localparam int RS_LSB     = 8;   // rs = instr[10:8]
  localparam int RT_LSB     = 5;   // rt = instr[7:5]
  localparam int IMM_MAX_W  = 11;  // widest immediate field, instr[10:0]
  localparam int IMM_LEN_W  = 4;

  typedef enum logic [1:0] {
    IMM_SEL_5    = 2'b00,
    IMM_SEL_8    = 2'b01,
    IMM_SEL_11   = 2'b10,
    IMM_SEL_RSVD = 2'b11
  } imm_sel_e;

  // Number of low instruction bits forming the immediate; the reserved
  // encoding behaves like the 5-bit form.
  function automatic logic [IMM_LEN_W-1:0] imm_len(input imm_sel_e sel);
    case (sel)
      IMM_SEL_8:  return IMM_LEN_W'(8);
      IMM_SEL_11: return IMM_LEN_W'(11);
      default:    return IMM_LEN_W'(5);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: decode_stage_if                                                 |
// | Purpose  : Upstream (instruction in) and downstream (decoded operands out) |
// |            valid/ready handshakes of the decode stage.                     |
// | Ports    : master - drives in_valid/instr/pc_in/se_immed/ze_immed/imm_sel  |
// |                     and out_ready; slave - the decode stage itself.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    instr;
  logic [DATA_W-1:0]     pc_in;
  logic                  se_immed;
  logic                  ze_immed;
  logic [1:0]            imm_sel;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     pc_out;
  logic [DATA_W-1:0]     ext_out;
  logic [DATA_W-1:0]     data_1;
  logic [DATA_W-1:0]     data_2;
  logic [REG_ADDR_W-1:0] rs_out;
  logic [REG_ADDR_W-1:0] rt_out;

  modport master (
    output in_valid, instr, pc_in, se_immed, ze_immed, imm_sel, out_ready,
    input  in_ready, out_valid, pc_out, ext_out, data_1, data_2, rs_out, rt_out
  );

  modport slave (
    input  in_valid, instr, pc_in, se_immed, ze_immed, imm_sel, out_ready,
    output in_ready, out_valid, pc_out, ext_out, data_1, data_2, rs_out, rt_out
  );
endinterface
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_bypass                                                  |
// | Purpose  : NUM_REGS x DATA_W register file, two combinational read ports,  |
// |            one write port, optional write-to-read forwarding.              |
// | Ports    : clk, rst_n (async, active low, clears every entry)              |
// |            wr_en_i/wr_addr_i/wr_data_i    - write port, commits on edge    |
// |            rd_addr_1_i -> rd_data_1_o     - read port 1                    |
// |            rd_addr_2_i -> rd_data_2_o     - read port 2                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_bypass
  import decode_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int BYPASS   = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  wr_en_i,
  input  wire logic [REG_ADDR_W-1:0] wr_addr_i,
  input  wire logic [DATA_W-1:0]     wr_data_i,
  input  wire logic [REG_ADDR_W-1:0] rd_addr_1_i,
  output logic      [DATA_W-1:0]     rd_data_1_o,
  input  wire logic [REG_ADDR_W-1:0] rd_addr_2_i,
  output logic      [DATA_W-1:0]     rd_data_2_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] rd_raw_1;
  logic [DATA_W-1:0] rd_raw_2;

  // Only entries that exist are ever matched, so writes to addresses beyond
  // NUM_REGS fall on the floor and reads of them return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && (wr_addr_i == REG_ADDR_W'(i))) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    rd_raw_1 = '0;
    rd_raw_2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_1_i == REG_ADDR_W'(i)) rd_raw_1 = mem_q[i];
      if (rd_addr_2_i == REG_ADDR_W'(i)) rd_raw_2 = mem_q[i];
    end
  end

  if (BYPASS != 0) begin : g_bypass
    logic wr_in_range;
    logic hit_1;
    logic hit_2;

    // Forwarding must not resurrect a write that the array would discard.
    assign wr_in_range = (int'(wr_addr_i) < NUM_REGS);
    assign hit_1       = wr_en_i && wr_in_range && (wr_addr_i == rd_addr_1_i);
    assign hit_2       = wr_en_i && wr_in_range && (wr_addr_i == rd_addr_2_i);
    assign rd_data_1_o = hit_1 ? wr_data_i : rd_raw_1;
    assign rd_data_2_o = hit_2 ? wr_data_i : rd_raw_2;
  end else begin : g_no_bypass
    assign rd_data_1_o = rd_raw_1;
    assign rd_data_2_o = rd_raw_2;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_stage                                                    |
// | Purpose  : Single-entry pipeline decode register. Reads rs/rt operands,    |
// |            extends the immediate and captures the PC; stalls on a          |
// |            load-use hazard against the load in execute.                    |
// | Ports    : clk, rst_n         - clock, async active-low reset              |
// |            bus (slave)        - upstream/downstream valid-ready handshakes |
// |            flush              - drop held output and the incoming instr    |
// |            wb_en/wb_reg/wb_data - register write-back port                 |
// |            ex_load/ex_dst     - load in execute and its destination        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int BYPASS   = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  decode_stage_if.slave              bus,
  input  wire logic                  flush,
  input  wire logic                  wb_en,
  input  wire logic [REG_ADDR_W-1:0] wb_reg,
  input  wire logic [DATA_W-1:0]     wb_data,
  input  wire logic                  ex_load,
  input  wire logic [REG_ADDR_W-1:0] ex_dst
);

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  hazard;
  logic                  in_ready;
  logic                  transfer;

  logic [IMM_MAX_W-1:0]  imm_field;
  logic [IMM_LEN_W-1:0]  imm_width;
  logic                  imm_sign;
  logic [DATA_W-1:0]     imm_mask;
  logic [DATA_W-1:0]     ext_d;

  logic [DATA_W-1:0]     rd_data_1;
  logic [DATA_W-1:0]     rd_data_2;

  logic                  out_valid_q;
  logic [DATA_W-1:0]     pc_q;
  logic [DATA_W-1:0]     ext_q;
  logic [DATA_W-1:0]     data_1_q;
  logic [DATA_W-1:0]     data_2_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;

  assign rs = bus.instr[RS_LSB +: REG_ADDR_W];
  assign rt = bus.instr[RT_LSB +: REG_ADDR_W];

  // A load in execute has not produced its data yet, so any instruction that
  // reads its destination must wait in front of this stage.
  assign hazard   = bus.in_valid && ex_load && ((ex_dst == rs) || (ex_dst == rt));
  assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !flush;
  assign transfer = bus.in_valid && in_ready;

  assign bus.in_ready = in_ready;

  regfile_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wb_en),
    .wr_addr_i   (wb_reg),
    .wr_data_i   (wb_data),
    .rd_addr_1_i (rs),
    .rd_data_1_o (rd_data_1),
    .rd_addr_2_i (rt),
    .rd_data_2_o (rd_data_2)
  );

  // Immediate extension: the field is the low imm_width bits; bits above it
  // are filled with the field's top bit when sign-extending, else zero.
  assign imm_field = bus.instr[IMM_MAX_W-1:0];
  assign imm_width = imm_len(imm_sel_e'(bus.imm_sel));
  assign imm_mask  = ~({DATA_W{1'b1}} << imm_width);

  always_comb begin
    imm_sign = 1'b0;
    case (imm_sel_e'(bus.imm_sel))
      IMM_SEL_8:  imm_sign = imm_field[7];
      IMM_SEL_11: imm_sign = imm_field[10];
      default:    imm_sign = imm_field[4];
    endcase
  end

  always_comb begin
    ext_d = '0;
    if (bus.se_immed) begin
      ext_d = (DATA_W'(imm_field) & imm_mask) | (imm_sign ? ~imm_mask : '0);
    end else if (bus.ze_immed) begin
      ext_d = DATA_W'(imm_field) & imm_mask;
    end
  end

  // Flush beats everything; otherwise a transfer loads, and a consumed output
  // with nothing behind it becomes a bubble. A stalled output simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      ext_q       <= '0;
      data_1_q    <= '0;
      data_2_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      pc_q        <= bus.pc_in;
      ext_q       <= ext_d;
      data_1_q    <= rd_data_1;
      data_2_q    <= rd_data_2;
      rs_q        <= rs;
      rt_q        <= rt;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pc_out    = pc_q;
  assign bus.ext_out   = ext_q;
  assign bus.data_1    = data_1_q;
  assign bus.data_2    = data_2_q;
  assign bus.rs_out    = rs_q;
  assign bus.rt_out    = rt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_decode_stage                                                 |
// | Purpose  : Scoreboard bench for decode_stage. Two instances share stimulus:|
// |            A = 8 regs with bypass, B = 4 regs without bypass.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DW   = 16;
  localparam int NR_A = 8;
  localparam int NR_B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        ex_load;
  logic [2:0]  ex_dst;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DW)) ifa ();
  decode_stage_if #(.DATA_W(DW)) ifb ();

  decode_stage #(.DATA_W(DW), .NUM_REGS(NR_A), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .flush(flush), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .ex_load(ex_load), .ex_dst(ex_dst)
  );

  decode_stage #(.DATA_W(DW), .NUM_REGS(NR_B), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .flush(flush), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .ex_load(ex_load), .ex_dst(ex_dst)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ext;
    logic [15:0] d1a;
    logic [15:0] d2a;
    logic [15:0] d1b;
    logic [15:0] d2b;
    logic [2:0]  rs;
    logic [2:0]  rt;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mdl_regs [8];
  int          checks   = 0;
  int          failures = 0;
  logic        exp_in_ready;
  logic        mon_en;

  // Stimulus for the next cycle, filled by the caller before step().
  logic        s_iv, s_se, s_ze, s_ordy, s_fl, s_we, s_el;
  logic [15:0] s_ins, s_pc, s_wd;
  logic [1:0]  s_sel;
  logic [2:0]  s_wr, s_ed;

  // Effects of the current cycle that take hold on the next rising edge.
  logic        pend_push, pend_flush, pend_we;
  exp_t        pend_e;
  logic [2:0]  pend_wr;
  logic [15:0] pend_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_ext(input logic [15:0] ins, input logic [1:0] sel,
                                          input logic se, input logic ze);
    int len;
    int v;
    len = (sel == 2'b01) ? 8 : (sel == 2'b10) ? 11 : 5;
    v   = int'(ins) % (1 << len);
    if (se) begin
      if (v >= (1 << (len - 1))) v = v - (1 << len);
      return 16'(v);
    end
    if (ze) return 16'(v);
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ref_read(input logic [2:0] addr, input int nregs, input bit byp,
                                           input logic we, input logic [2:0] wr, input logic [15:0] wd);
    if (int'(addr) >= nregs) return 16'h0000;
    if (byp && we && (wr == addr)) return wd;
    return mdl_regs[addr];
  endfunction

  task automatic set_idle();
    s_iv = 0; s_se = 0; s_ze = 0; s_ordy = 1; s_fl = 0; s_we = 0; s_el = 0;
    s_ins = '0; s_pc = '0; s_wd = '0; s_sel = '0; s_wr = '0; s_ed = '0;
  endtask

  task automatic apply_inputs();
    ifa.in_valid = s_iv; ifa.instr = s_ins; ifa.pc_in = s_pc; ifa.se_immed = s_se;
    ifa.ze_immed = s_ze; ifa.imm_sel = s_sel; ifa.out_ready = s_ordy;
    ifb.in_valid = s_iv; ifb.instr = s_ins; ifb.pc_in = s_pc; ifb.se_immed = s_se;
    ifb.ze_immed = s_ze; ifb.imm_sel = s_sel; ifb.out_ready = s_ordy;
    flush = s_fl; wb_en = s_we; wb_reg = s_wr; wb_data = s_wd; ex_load = s_el; ex_dst = s_ed;
  endtask

  task automatic clear_model();
    sb_q.delete();
    for (int i = 0; i < 8; i++) mdl_regs[i] = '0;
    pend_push = 0; pend_flush = 0; pend_we = 0;
  endtask

  task automatic step();
    logic [2:0] rs, rt;
    logic       hz;
    @(posedge clk);
    if (pend_flush) sb_q.delete();
    else if (pend_push) sb_q.push_back(pend_e);
    if (pend_we) mdl_regs[pend_wr] = pend_wd;
    #1;
    apply_inputs();
    rs = s_ins[10:8];
    rt = s_ins[7:5];
    hz = s_iv && s_el && ((s_ed == rs) || (s_ed == rt));
    exp_in_ready = ((sb_q.size() == 0) || s_ordy) && !hz && !s_fl;
    pend_push  = s_iv && exp_in_ready;
    pend_flush = s_fl;
    pend_we = s_we; pend_wr = s_wr; pend_wd = s_wd;
    pend_e.pc  = s_pc;
    pend_e.ext = ref_ext(s_ins, s_sel, s_se, s_ze);
    pend_e.d1a = ref_read(rs, NR_A, 1, s_we, s_wr, s_wd);
    pend_e.d2a = ref_read(rt, NR_A, 1, s_we, s_wr, s_wd);
    pend_e.d1b = ref_read(rs, NR_B, 0, s_we, s_wr, s_wd);
    pend_e.d2b = ref_read(rt, NR_B, 0, s_we, s_wr, s_wd);
    pend_e.rs  = rs;
    pend_e.rt  = rt;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid_a"}, ifa.out_valid, 0); chk({tag, "_valid_b"}, ifb.out_valid, 0);
    chk({tag, "_pc_a"}, ifa.pc_out, 0);       chk({tag, "_ext_a"}, ifa.ext_out, 0);
    chk({tag, "_d1_a"}, ifa.data_1, 0);       chk({tag, "_d2_a"}, ifa.data_2, 0);
    chk({tag, "_rs_a"}, ifa.rs_out, 0);       chk({tag, "_rt_a"}, ifa.rt_out, 0);
    chk({tag, "_d1_b"}, ifb.data_1, 0);       chk({tag, "_d2_b"}, ifb.data_2, 0);
  endtask

  // Called at posedge+1 in the middle of a cycle: reset lands between edges.
  task automatic do_reset(input string tag);
    #2;
    mon_en = 0;
    rst_n  = 0;
    #1;
    check_outputs_zero(tag);
    clear_model();
    set_idle();
    apply_inputs();
    exp_in_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1;
    mon_en = 1;
  endtask

  // Monitor: compares whatever the DUTs present against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        chk("in_ready_a", ifa.in_ready, exp_in_ready);
        chk("in_ready_b", ifb.in_ready, exp_in_ready);
        chk("out_valid_a", ifa.out_valid, sb_q.size() != 0);
        chk("out_valid_b", ifb.out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
          chk("pc_a",  ifa.pc_out,  sb_q[0].pc);
          chk("ext_a", ifa.ext_out, sb_q[0].ext);
          chk("d1_a",  ifa.data_1,  sb_q[0].d1a);
          chk("d2_a",  ifa.data_2,  sb_q[0].d2a);
          chk("rs_a",  ifa.rs_out,  sb_q[0].rs);
          chk("rt_a",  ifa.rt_out,  sb_q[0].rt);
          chk("pc_b",  ifb.pc_out,  sb_q[0].pc);
          chk("ext_b", ifb.ext_out, sb_q[0].ext);
          chk("d1_b",  ifb.data_1,  sb_q[0].d1b);
          chk("d2_b",  ifb.data_2,  sb_q[0].d2b);
          if (ifa.out_ready && !flush) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    mon_en = 0;
    rst_n  = 0;
    clear_model();
    set_idle();
    apply_inputs();
    exp_in_ready = 1;
    #1;
    check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1;
    mon_en = 1;

    // Write R3, then read it back through rs.
    set_idle(); s_we = 1; s_wr = 3; s_wd = 16'h1234; step();
    set_idle(); s_iv = 1; s_ins = 16'h0300; s_pc = 16'h0100; step();
    set_idle(); step();

    // Same-cycle write-back: A forwards, B captures the old R2.
    set_idle(); s_we = 1; s_wr = 2; s_wd = 16'h1111; step();
    set_idle(); s_iv = 1; s_ins = 16'h0040; s_pc = 16'h0102;
    s_we = 1; s_wr = 2; s_wd = 16'hBEEF; step();
    // rt = 5: out of range for B, forwarded in A.
    set_idle(); s_iv = 1; s_ins = 16'h00A0; s_we = 1; s_wr = 5; s_wd = 16'hBEEF; step();

    // Immediate extension of an 8-bit field with its sign bit set.
    set_idle(); s_iv = 1; s_ins = 16'h0080; s_sel = 2'b01; s_se = 1; step();
    set_idle(); s_iv = 1; s_ins = 16'h0080; s_sel = 2'b01; s_ze = 1; step();
    set_idle(); s_iv = 1; s_ins = 16'h0080; s_sel = 2'b01; s_se = 1; s_ze = 1; step();
    set_idle(); s_iv = 1; s_ins = 16'h0490; s_sel = 2'b10; s_se = 1; step();
    set_idle(); s_iv = 1; s_ins = 16'h0010; s_sel = 2'b11; s_se = 1; step();
    set_idle(); step();

    // Load-use hazard on rs = 2 stalls, then is accepted once the load moves on.
    for (int i = 0; i < 2; i++) begin
      set_idle(); s_iv = 1; s_ins = 16'h0200; s_pc = 16'h0200; s_el = 1; s_ed = 2; step();
    end
    set_idle(); s_iv = 1; s_ins = 16'h0200; s_pc = 16'h0200; step();
    set_idle(); step();

    // Downstream stall for three cycles, then flush with an instruction waiting.
    set_idle(); s_iv = 1; s_ins = 16'h0360; s_pc = 16'h0300; s_ordy = 0; step();
    for (int i = 0; i < 3; i++) begin
      set_idle(); s_iv = 1; s_ins = 16'h0120; s_pc = 16'h0304; s_ordy = 0; step();
    end
    set_idle(); s_iv = 1; s_ins = 16'h0120; s_pc = 16'h0304; s_ordy = 0; s_fl = 1;
    s_we = 1; s_wr = 1; s_wd = 16'h5A5A; step();
    set_idle(); s_iv = 1; s_ins = 16'h0120; s_pc = 16'h0308; step();
    set_idle(); step();

    // Reset in the middle of a stall, then R3 must read back as zero.
    set_idle(); s_iv = 1; s_ins = 16'h0300; s_pc = 16'h0400; s_ordy = 0; step();
    set_idle(); s_ordy = 0; step();
    do_reset("midreset");
    set_idle(); s_iv = 1; s_ins = 16'h0360; s_pc = 16'h0404; step();
    set_idle(); step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      s_iv   = ($urandom_range(0, 3) != 0);
      s_ins  = 16'($urandom());
      s_pc   = 16'($urandom());
      s_se   = ($urandom_range(0, 2) == 0);
      s_ze   = ($urandom_range(0, 1) == 0);
      s_sel  = 2'($urandom_range(0, 3));
      s_ordy = ($urandom_range(0, 9) < 7);
      s_fl   = ($urandom_range(0, 15) == 0);
      s_we   = ($urandom_range(0, 1) == 0);
      s_wr   = 3'($urandom_range(0, 7));
      s_wd   = 16'($urandom());
      s_el   = ($urandom_range(0, 3) == 0);
      s_ed   = 3'($urandom_range(0, 7));
      step();
    end
    set_idle(); step();
    set_idle(); step();
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the datapath width of register data, PC and extended immediate; legal values are 16 and 32.
REQ-002 Parameter NUM_REGS, default 8, SHALL set the register-file depth; legal values are 2, 4 and 8.
REQ-003 Parameter BYPASS, default 1, SHALL enable (1) or disable (0) the write-back-to-read bypass.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid, in_ready  input/output  1 each  upstream handshake for instr, pc_in, se_immed, ze_immed and imm_sel.
REQ-007 instr  input  16  instruction word: rs = instr[10:8], rt = instr[7:5].
REQ-008 pc_in  input  DATA_W  sequential PC of instr.
REQ-009 se_immed, ze_immed  input  1 each  sign- or zero-extend select.
REQ-010 imm_sel  input  2  immediate length: 00 = instr[4:0], 01 = instr[7:0], 10 = instr[10:0], 11 = reserved (treated as 00).
REQ-011 flush  input  1  discard the held output and the accepting input.
REQ-012 wb_en, wb_reg, wb_data  input  1/3/DATA_W  register write port.
REQ-013 ex_load, ex_dst  input  1/3  load currently in execute and its destination register.
REQ-014 out_valid, out_ready  output/input  1 each  downstream handshake.
REQ-015 pc_out, ext_out, data_1, data_2  output  DATA_W each  registered PC, immediate, rs data and rt data.
REQ-016 rs_out, rt_out  output  3 each  registered source register numbers.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush, combinationally.
REQ-018 hazard SHALL be asserted when in_valid && ex_load and ex_dst equals rs or rt.
REQ-019 A transfer SHALL occur when in_valid && in_ready; the output registers SHALL load on the next edge, giving a latency of one cycle.
REQ-020 If out_valid && out_ready and no transfer occurs, out_valid SHALL clear on that edge (a bubble is inserted).
REQ-021 If out_valid && !out_ready, every output SHALL hold its value unchanged.
REQ-022 flush SHALL clear out_valid on the next edge, overriding every other condition; register writes SHALL still occur during flush.
REQ-023 Register reads SHALL be combinational from the register file; an address >= NUM_REGS SHALL read as 0, and a write to such an address SHALL be ignored.
REQ-024 When BYPASS=1, wb_en && wb_reg == rs (or rt) SHALL forward wb_data into data_1 (or data_2) in the same cycle; when BYPASS=0, the old register value SHALL be captured.
REQ-025 The write SHALL commit on the edge when wb_en=1; R0 is an ordinary writable register.
REQ-026 ext_out extension rules:
 - se_immed=1: sign-extend the selected field to DATA_W;
 - else if ze_immed=1: zero-extend the selected field;
 - else: ext_out = 0;
 - se_immed SHALL win if both are set.
REQ-027 pc_out SHALL be pc_in captured unmodified.

Reset
REQ-028 While rst_n=0, out_valid, all data outputs, rs_out, rt_out and every register-file entry SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 A reset mid-stall SHALL drop the held instruction; in_ready SHALL be 1 in the first cycle after release unless hazard or flush is asserted.

Structure
REQ-030 A shared package decode_pkg SHALL hold the imm_sel encodings, the field bit positions and the DATA_W and NUM_REGS defaults.
REQ-031 The register file SHALL be a separate sub-module, regfile_bypass (2 read ports, 1 write port, BYPASS parameter).

Verification
REQ-032 Write R3 = 0x1234 with wb_en, then issue instr with rs=3 -> one cycle later out_valid=1 and data_1=0x1234.
REQ-033 BYPASS=1, same-cycle wb_reg=5, wb_data=0xBEEF and instr rt=5 -> data_2=0xBEEF; with BYPASS=0 -> data_2 = the old value.
REQ-034 imm_sel=01, instr[7:0]=0x80, se_immed=1 -> ext_out=0xFF80; with ze_immed=1 only -> ext_out=0x0080.
REQ-035 ex_load=1, ex_dst=2, instr rs=2 -> in_ready=0 and a bubble is produced (out_valid=0); when ex_load drops, the instruction is accepted.
REQ-036 out_ready=0 for 3 cycles with a valid output -> outputs stable; assert flush -> out_valid=0 on the next edge.
REQ-037 Assert rst_n=0 mid-stall -> all outputs 0 asynchronously; a register read after reset returns 0.
